// File: rtl/sequenciador_polinomio.sv
// Sequencer that walks PONTOS points X = x0 + i*passo through the polynomial evaluator handshake.
// Optional per-point watchdog enabled by defining SEQ_TIMEOUT_EN.
module sequenciador_polinomio #(
  parameter int W       = 16,
  parameter int PONTOS  = 8,
  parameter int TIMEOUT = 255,
  parameter int AW      = (PONTOS > 1) ? $clog2(PONTOS) : 1
) (
  input  logic          ck_i,
  input  logic          rst_ni,
  input  logic          start_i,
  input  logic [W-1:0]  x0_i,
  input  logic [W-1:0]  passo_i,
  input  logic [W-1:0]  coef_a_i,
  input  logic [W-1:0]  coef_b_i,
  input  logic [W-1:0]  coef_c_i,
  output logic          inicio_o,
  output logic [W-1:0]  x_o,
  output logic [W-1:0]  a_o,
  output logic [W-1:0]  b_o,
  output logic [W-1:0]  c_o,
  input  logic          pronto_i,
  input  logic [W-1:0]  resultado_i,
  input  logic          overflow_i,
  output logic          ocupado_o,
  output logic          concluido_o,
  output logic [AW:0]   n_overflow_o,
  output logic          erro_timeout_o,
  input  logic [AW-1:0] rd_addr_i,
  output logic [W-1:0]  rd_data_o,
  output logic          rd_ovf_o
);

  localparam logic [AW-1:0] LAST = AW'(PONTOS - 1);

  // IDLE waits for start | START drives inicio | WAIT awaits pronto rise | DONE pulses concluido
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  x_q, x_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  c_q, c_d;
  logic [W-1:0]  passo_q, passo_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [AW:0]   nov_q, nov_d;
  logic          pronto_q;
  logic          pronto_rise;
  logic          wr_en;
  logic [W-1:0]  rd_data_q;
  logic          rd_ovf_q;
  logic [W:0]    mem_q [PONTOS];

`ifdef SEQ_TIMEOUT_EN
  localparam int CW = 16;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          erro_q, erro_d;
`endif

  // A pronto still high from the previous point (or an aborted run) never reads as a new rise.
  assign pronto_rise = pronto_i & ~pronto_q;

  always_ff @(posedge ck_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      x_q      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      passo_q  <= '0;
      idx_q    <= '0;
      nov_q    <= '0;
      pronto_q <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
      cnt_q    <= '0;
      erro_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      a_q      <= a_d;
      b_q      <= b_d;
      c_q      <= c_d;
      passo_q  <= passo_d;
      idx_q    <= idx_d;
      nov_q    <= nov_d;
      pronto_q <= pronto_i;
`ifdef SEQ_TIMEOUT_EN
      cnt_q    <= cnt_d;
      erro_q   <= erro_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    passo_d = passo_q;
    idx_d   = idx_q;
    nov_d   = nov_q;
    wr_en   = 1'b0;
`ifdef SEQ_TIMEOUT_EN
    cnt_d   = cnt_q;
    erro_d  = erro_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          x_d     = x0_i;
          a_d     = coef_a_i;
          b_d     = coef_b_i;
          c_d     = coef_c_i;
          passo_d = passo_i;
          idx_d   = '0;
          nov_d   = '0;
`ifdef SEQ_TIMEOUT_EN
          erro_d  = 1'b0;
`endif
          state_d = START;
        end
      end
      START: begin
`ifdef SEQ_TIMEOUT_EN
        cnt_d   = '0;
`endif
        state_d = WAIT;
      end
      WAIT: begin
        if (pronto_rise) begin
          wr_en = 1'b1;
          nov_d = nov_q + {{AW{1'b0}}, overflow_i};
          if (idx_q == LAST) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + AW'(1);
            x_d     = x_q + passo_q;
            state_d = START;
          end
        end
`ifdef SEQ_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT - 1)) begin
          erro_d  = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
`endif
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Buffer is deliberately left out of reset so results survive an abort.
  always_ff @(posedge ck_i) begin
    if (wr_en) begin
      mem_q[idx_q] <= {overflow_i, resultado_i};
    end
  end

  always_ff @(posedge ck_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_data_q <= '0;
      rd_ovf_q  <= 1'b0;
    end else begin
      {rd_ovf_q, rd_data_q} <= mem_q[rd_addr_i];
    end
  end

  assign inicio_o     = (state_q == START);
  assign concluido_o  = (state_q == DONE);
  assign ocupado_o    = (state_q != IDLE);
  assign x_o          = x_q;
  assign a_o          = a_q;
  assign b_o          = b_q;
  assign c_o          = c_q;
  assign n_overflow_o = nov_q;
  assign rd_data_o    = rd_data_q;
  assign rd_ovf_o     = rd_ovf_q;

`ifdef SEQ_TIMEOUT_EN
  assign erro_timeout_o = erro_q;
`else
  assign erro_timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_sequenciador_polinomio.sv
// Scoreboard bench for sequenciador_polinomio with a latency-5 evaluator model f = A*X*X + B*X + C.
module tb_sequenciador_polinomio;
  localparam int W   = 16;
  localparam int P   = 4;
  localparam int AW  = 2;
  localparam int LAT = 5;

  logic          ck = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [W-1:0]  x0 = '0, passo = '0, ca = '0, cb = '0, cc = '0;
  logic          pronto = 1'b0;
  logic [W-1:0]  resultado = '0;
  logic          ovf = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic          inicio_o, ocupado_o, concluido_o, erro_o, rd_ovf_o;
  logic [W-1:0]  x_o, a_o, b_o, c_o, rd_data_o;
  logic [AW:0]   nov_o;

  sequenciador_polinomio #(.W(W), .PONTOS(P), .TIMEOUT(255)) dut (
    .ck_i(ck), .rst_ni(rst_n), .start_i(start),
    .x0_i(x0), .passo_i(passo), .coef_a_i(ca), .coef_b_i(cb), .coef_c_i(cc),
    .inicio_o(inicio_o), .x_o(x_o), .a_o(a_o), .b_o(b_o), .c_o(c_o),
    .pronto_i(pronto), .resultado_i(resultado), .overflow_i(ovf),
    .ocupado_o(ocupado_o), .concluido_o(concluido_o), .n_overflow_o(nov_o),
    .erro_timeout_o(erro_o), .rd_addr_i(rd_addr), .rd_data_o(rd_data_o), .rd_ovf_o(rd_ovf_o)
  );

  always #5 ck = ~ck;

  typedef struct packed {
    logic [W-1:0] x;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] c;
  } op_t;

  op_t          exp_op_q[$];
  int           exp_nov_q[$];
  logic [W-1:0] exp_mem [P];
  logic         exp_ovf [P];
  int           checks = 0;
  int           errors = 0;
  int           n_inicio = 0;
  int           n_done = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] poly(input logic [W-1:0] a, b, c, x);
    return 64'(a) * 64'(x) * 64'(x) + 64'(b) * 64'(x) + 64'(c);
  endfunction

  // Evaluator: captures operands on inicio, drops pronto, raises it LAT cycles later and holds it.
  initial begin
    int cnt;
    op_t cur;
    logic [63:0] f;
    cnt = 0;
    cur = '0;
    forever begin
      @(negedge ck);
      if (inicio_o) begin
        cur = '{x: x_o, a: a_o, b: b_o, c: c_o};
        pronto = 1'b0;
        cnt = LAT;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          f = poly(cur.a, cur.b, cur.c, cur.x);
          resultado = f[W-1:0];
          ovf = (f >= 64'h10000);
          pronto = 1'b1;
        end
      end
    end
  end

  // Monitor: every inicio and concluido the DUT presents is matched against the scoreboard.
  initial begin
    op_t e;
    int en;
    forever begin
      @(negedge ck);
      if (rst_n) begin
        if (inicio_o) begin
          n_inicio++;
          if (exp_op_q.size() == 0) chk("unexpected_inicio", 1, 0);
          else begin
            e = exp_op_q.pop_front();
            chk("operands", {x_o, a_o, b_o, c_o}, e);
          end
        end
        if (concluido_o) begin
          n_done++;
          if (exp_nov_q.size() == 0) chk("unexpected_concluido", 1, 0);
          else begin
            en = exp_nov_q.pop_front();
            chk("n_overflow", nov_o, en);
          end
          chk("erro_timeout", erro_o, 0);
        end
      end
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ctrl"}, {inicio_o, ocupado_o, concluido_o, erro_o, nov_o, rd_ovf_o, rd_data_o}, 0);
    chk({tag, "_data"}, {x_o, a_o, b_o, c_o}, 0);
  endtask

  task automatic wait_inicio(input int k);
    bit hit;
    hit = 0;
    for (int n = 0; n < 500; n++) begin
      @(negedge ck);
      #1;
      if (n_inicio >= k) begin
        hit = 1;
        break;
      end
    end
    if (!hit) chk("inicio_wait_expired", 0, 1);
  endtask

  task automatic do_run(input logic [W-1:0] x0v, pv, av, bv, cv, input bit poke, input int abort_pt);
    int nov;
    logic [W-1:0] xi;
    logic [63:0] f;
    bit hit;
    nov = 0;
    for (int i = 0; i < P; i++) begin
      xi = x0v + W'(i * int'(pv));
      f = poly(av, bv, cv, xi);
      if (abort_pt < 0) begin
        exp_mem[i] = f[W-1:0];
        exp_ovf[i] = (f >= 64'h10000);
      end
      exp_op_q.push_back('{x: xi, a: av, b: bv, c: cv});
      if (f >= 64'h10000) nov++;
    end
    exp_nov_q.push_back(nov);
    n_inicio = 0;
    n_done = 0;
    @(negedge ck);
    x0 = x0v; passo = pv; ca = av; cb = bv; cc = cv;
    start = 1'b1;
    @(negedge ck);
    start = 1'b0;
    x0 = W'($urandom); passo = W'($urandom); ca = W'($urandom); cb = W'($urandom); cc = W'($urandom);
    if (poke) begin
      wait_inicio(2);
      @(negedge ck);
      start = 1'b1;
      @(negedge ck);
      start = 1'b0;
    end
    if (abort_pt >= 0) begin
      wait_inicio(abort_pt + 1);
      @(negedge ck);
      #2 rst_n = 1'b0;
      #1 chk_reset_outputs("abort");
      exp_op_q.delete();
      exp_nov_q.delete();
      repeat (3) @(negedge ck);
      rst_n = 1'b1;
      return;
    end
    hit = 0;
    for (int n = 0; n < 1000; n++) begin
      @(negedge ck);
      #1;
      if (n_done >= 1) begin
        hit = 1;
        break;
      end
    end
    if (!hit) chk("concluido_wait_expired", 0, 1);
    repeat (6) @(negedge ck);
    chk("inicio_count", n_inicio, P);
    chk("concluido_count", n_done, 1);
    chk("ocupado_after_run", ocupado_o, 0);
    chk("leftover_ops", exp_op_q.size(), 0);
    for (int i = 0; i < P; i++) begin
      @(negedge ck);
      rd_addr = AW'(i);
      @(negedge ck);
      chk("rd_data", rd_data_o, exp_mem[i]);
      chk("rd_ovf", rd_ovf_o, exp_ovf[i]);
    end
  endtask

  initial begin
    #1 chk_reset_outputs("reset");
    repeat (3) @(negedge ck);
    rst_n = 1'b1;
    do_run(16'h0000, 16'h0001, 16'd1, 16'd2, 16'd3, 1'b0, -1);
    do_run(16'hFFFF, 16'h0001, 16'd0, 16'd1, 16'd0, 1'b0, -1);
    do_run(16'h0100, 16'h0001, 16'd1, 16'd0, 16'd0, 1'b0, -1);
    do_run(16'h0005, 16'h0003, 16'd2, 16'd7, 16'd1, 1'b1, -1);
    do_run(16'h0000, 16'h0001, 16'd1, 16'd2, 16'd3, 1'b0, 2);
    do_run(16'h0010, 16'h0002, 16'd1, 16'd1, 16'd1, 1'b0, -1);
    for (int r = 0; r < 8; r++) begin
      if (r < 4)
        do_run(W'($urandom_range(0, 300)), W'($urandom_range(0, 40)), W'($urandom_range(0, 3)),
               W'($urandom_range(0, 50)), W'($urandom), 1'b0, -1);
      else
        do_run(W'($urandom), W'($urandom), W'($urandom), W'($urandom), W'($urandom), 1'b0, -1);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
